rr_fifo_arbiter: RTL and testbench

- Round-robin arbiter and 4x4 switch between four show-ahead input FIFOs (P0..P3) and four output FIFOs (F0..F3).
- Each 10-bit word carries its destination in bits [DEST_MSB:DEST_MSB-1].
- Per cycle, grants at most one input whose destination is not almost-full, then pops that input and pushes the word to its destination in the same cycle.
- Replaces the fixed-priority pop/push control with fair, per-destination flow control.

---
 rtl/rr_fifo_arbiter.sv | 161 ++++++++++++++++
 tb/tb_rr_fifo_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rr_fifo_arbiter.sv
// rr_fifo_arbiter: fair round-robin 4x4 switch from four show-ahead input FIFOs to four output FIFOs; `define RR_STATS_EN adds grant/stall counters.
// Latency: heads sampled at edge E produce pop/push/data registered at E, acted on by the FIFOs at E+1; no word is held inside.
// Backpressure: inputs whose destination is almost full are skipped; almost_full must leave >=2 free entries since a push is seen one edge late.
module rr_fifo_arbiter #(
   parameter int DATA_W   = 10,
   parameter int DEST_MSB = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              empty_P0,
   input  logic              empty_P1,
   input  logic              empty_P2,
   input  logic              empty_P3,
   input  logic [DATA_W-1:0] in_FIFO_0,
   input  logic [DATA_W-1:0] in_FIFO_1,
   input  logic [DATA_W-1:0] in_FIFO_2,
   input  logic [DATA_W-1:0] in_FIFO_3,
   input  logic              almost_full_P0,
   input  logic              almost_full_P1,
   input  logic              almost_full_P2,
   input  logic              almost_full_P3,
   output logic              pop_F0,
   output logic              pop_F1,
   output logic              pop_F2,
   output logic              pop_F3,
   output logic              push_F0,
   output logic              push_F1,
   output logic              push_F2,
   output logic              push_F3,
   output logic [DATA_W-1:0] out_FIFO_0,
   output logic [DATA_W-1:0] out_FIFO_1,
   output logic [DATA_W-1:0] out_FIFO_2,
   output logic [DATA_W-1:0] out_FIFO_3,
   output logic              busy
`ifdef RR_STATS_EN
   ,
   input  logic              stats_clr,
   output logic [7:0]        grant_cnt_0,
   output logic [7:0]        grant_cnt_1,
   output logic [7:0]        grant_cnt_2,
   output logic [7:0]        grant_cnt_3,
   output logic [7:0]        stall_cnt
`endif
);

   logic [3:0]             empty_v;
   logic [3:0]             afull_v;
   logic [3:0][DATA_W-1:0] head;
   logic [3:0]             elig;

   logic [1:0]             ptr_q;
   logic [3:0]             mask_q;
   logic [3:0]             pop_q;
   logic [3:0]             push_q;
   logic                   busy_q;
   logic [3:0][DATA_W-1:0] out_q;

   logic                   gnt_vld;
   logic [1:0]             gnt_idx;
   logic [1:0]             gnt_dest;
   logic [1:0]             cand;

   assign empty_v = {empty_P3, empty_P2, empty_P1, empty_P0};
   assign afull_v = {almost_full_P3, almost_full_P2, almost_full_P1, almost_full_P0};
   assign head    = {in_FIFO_3, in_FIFO_2, in_FIFO_1, in_FIFO_0};

   // The mask keeps a just-popped input out for one edge: its head/empty only update after the pop lands.
   always_comb begin
      elig = '0;
      for (int i = 0; i < 4; i++) begin
         elig[i] = enable & ~empty_v[i] & ~afull_v[head[i][DEST_MSB -: 2]] & ~mask_q[i];
      end
   end

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = ptr_q;
      cand    = ptr_q;
      for (int k = 1; k <= 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!gnt_vld && elig[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   assign gnt_dest = head[gnt_idx][DEST_MSB -: 2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q  <= 2'd3;
         mask_q <= '0;
         pop_q  <= '0;
         push_q <= '0;
         busy_q <= 1'b0;
         out_q  <= '0;
      end else begin
         busy_q <= gnt_vld;
         if (gnt_vld) begin
            ptr_q             <= gnt_idx;
            mask_q            <= 4'b0001 << gnt_idx;
            pop_q             <= 4'b0001 << gnt_idx;
            push_q            <= 4'b0001 << gnt_dest;
            out_q[gnt_dest]   <= head[gnt_idx];
         end else begin
            mask_q <= '0;
            pop_q  <= '0;
            push_q <= '0;
         end
      end
   end

   assign pop_F0     = pop_q[0];
   assign pop_F1     = pop_q[1];
   assign pop_F2     = pop_q[2];
   assign pop_F3     = pop_q[3];
   assign push_F0    = push_q[0];
   assign push_F1    = push_q[1];
   assign push_F2    = push_q[2];
   assign push_F3    = push_q[3];
   assign out_FIFO_0 = out_q[0];
   assign out_FIFO_1 = out_q[1];
   assign out_FIFO_2 = out_q[2];
   assign out_FIFO_3 = out_q[3];
   assign busy       = busy_q;

`ifdef RR_STATS_EN
   logic [3:0][7:0] gcnt_q;
   logic [7:0]      stall_q;
   logic            stall_evt;

   // A stall is pending work with grants allowed but nothing issued (mask bubble or full destination).
   assign stall_evt = enable & ~(&empty_v) & ~gnt_vld;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gcnt_q  <= '0;
         stall_q <= '0;
      end else if (stats_clr) begin
         gcnt_q  <= '0;
         stall_q <= '0;
      end else begin
         if (gnt_vld && gcnt_q[gnt_idx] != 8'hFF) begin
            gcnt_q[gnt_idx] <= gcnt_q[gnt_idx] + 8'd1;
         end
         if (stall_evt && stall_q != 8'hFF) begin
            stall_q <= stall_q + 8'd1;
         end
      end
   end

   assign grant_cnt_0 = gcnt_q[0];
   assign grant_cnt_1 = gcnt_q[1];
   assign grant_cnt_2 = gcnt_q[2];
   assign grant_cnt_3 = gcnt_q[3];
   assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Bench for rr_fifo_arbiter: directed per-cycle vectors feed an expectation queue checked by an independent monitor.
module tb_rr_fifo_arbiter;
   localparam int DATA_W = 10;

   logic clk = 1'b0;
   logic reset;
   logic enable;
   logic [3:0] empty_v;
   logic [3:0] af_v;
   logic [3:0][DATA_W-1:0] heads;
   logic pop_F0, pop_F1, pop_F2, pop_F3;
   logic push_F0, push_F1, push_F2, push_F3;
   logic [DATA_W-1:0] out_FIFO_0, out_FIFO_1, out_FIFO_2, out_FIFO_3;
   logic busy;
`ifdef RR_STATS_EN
   logic stats_clr;
   logic [7:0] grant_cnt_0, grant_cnt_1, grant_cnt_2, grant_cnt_3, stall_cnt;
`endif

   typedef struct packed {
      logic [3:0]             pop;
      logic [3:0]             push;
      logic                   busy;
      logic [3:0][DATA_W-1:0] outs;
   } exp_t;

   exp_t sb[$];
   logic [3:0][DATA_W-1:0] exp_out;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   rr_fifo_arbiter #(.DATA_W(DATA_W), .DEST_MSB(9)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .empty_P0(empty_v[0]), .empty_P1(empty_v[1]), .empty_P2(empty_v[2]), .empty_P3(empty_v[3]),
      .in_FIFO_0(heads[0]), .in_FIFO_1(heads[1]), .in_FIFO_2(heads[2]), .in_FIFO_3(heads[3]),
      .almost_full_P0(af_v[0]), .almost_full_P1(af_v[1]),
      .almost_full_P2(af_v[2]), .almost_full_P3(af_v[3]),
      .pop_F0(pop_F0), .pop_F1(pop_F1), .pop_F2(pop_F2), .pop_F3(pop_F3),
      .push_F0(push_F0), .push_F1(push_F1), .push_F2(push_F2), .push_F3(push_F3),
      .out_FIFO_0(out_FIFO_0), .out_FIFO_1(out_FIFO_1),
      .out_FIFO_2(out_FIFO_2), .out_FIFO_3(out_FIFO_3),
      .busy(busy)
`ifdef RR_STATS_EN
      , .stats_clr(stats_clr),
      .grant_cnt_0(grant_cnt_0), .grant_cnt_1(grant_cnt_1),
      .grant_cnt_2(grant_cnt_2), .grant_cnt_3(grant_cnt_3),
      .stall_cnt(stall_cnt)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int oh2i(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 0;
   endfunction

   // Drive one cycle of inputs and queue the hand-computed strobes for the edge that samples them.
   task automatic step(input logic en, input logic [3:0] emp, input logic [3:0] afv,
                       input logic [3:0] ep, input logic [3:0] eu);
      exp_t r;
      @(negedge clk);
      enable  = en;
      empty_v = emp;
      af_v    = afv;
      @(posedge clk);
      #1;
      if (ep != 4'b0000) exp_out[oh2i(eu)] = heads[oh2i(ep)];
      r.pop  = ep;
      r.push = eu;
      r.busy = (ep != 4'b0000);
      r.outs = exp_out;
      sb.push_back(r);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("pop",  64'({pop_F3, pop_F2, pop_F1, pop_F0}), 64'(e.pop));
         chk("push", 64'({push_F3, push_F2, push_F1, push_F0}), 64'(e.push));
         chk("busy", 64'(busy), 64'(e.busy));
         chk("out",  64'({out_FIFO_3, out_FIFO_2, out_FIFO_1, out_FIFO_0}), 64'(e.outs));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; enable = 1'b0; empty_v = 4'hF; af_v = 4'h0;
      heads = '0; exp_out = '0;
`ifdef RR_STATS_EN
      stats_clr = 1'b0;
`endif
      #3;
      chk("rst_pop",  64'({pop_F3, pop_F2, pop_F1, pop_F0}), 64'd0);
      chk("rst_push", 64'({push_F3, push_F2, push_F1, push_F0}), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out",  64'({out_FIFO_3, out_FIFO_2, out_FIFO_1, out_FIFO_0}), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // All four busy, dest = index: order 0,1,2,3,0
      heads = {10'h344, 10'h233, 10'h122, 10'h011};
      step(1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
      step(1'b1, 4'b0000, 4'b0000, 4'b0010, 4'b0010);
      step(1'b1, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
      step(1'b1, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
      step(1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0001);

      // Single active input: grant every other cycle
      heads[2] = 10'h2A5;
      step(1'b1, 4'b1011, 4'b0000, 4'b0100, 4'b0100);
      step(1'b1, 4'b1011, 4'b0000, 4'b0000, 4'b0000);
      step(1'b1, 4'b1011, 4'b0000, 4'b0100, 4'b0100);
      step(1'b1, 4'b1011, 4'b0000, 4'b0000, 4'b0000);
      step(1'b1, 4'b1011, 4'b0000, 4'b0100, 4'b0100);
      step(1'b1, 4'b1011, 4'b0000, 4'b0000, 4'b0000);

      // P0, P1 both to dest 3: blocked, then alternate
      heads[0] = 10'h3C1; heads[1] = 10'h3D2;
      step(1'b1, 4'b1100, 4'b1000, 4'b0000, 4'b0000);
      step(1'b1, 4'b1100, 4'b1000, 4'b0000, 4'b0000);
      step(1'b1, 4'b1100, 4'b0000, 4'b0001, 4'b1000);
      step(1'b1, 4'b1100, 4'b0000, 4'b0010, 4'b1000);
      step(1'b1, 4'b1100, 4'b0000, 4'b0001, 4'b1000);
      step(1'b1, 4'b1100, 4'b0000, 4'b0010, 4'b1000);

      // P0 blocked by dest 1, P3 free; then search restarts at P0
      heads[0] = 10'h1E7; heads[3] = 10'h0F8;
      step(1'b1, 4'b0110, 4'b0010, 4'b1000, 4'b0001);
      step(1'b1, 4'b0110, 4'b0010, 4'b0000, 4'b0000);
      step(1'b1, 4'b0110, 4'b0000, 4'b0001, 4'b0010);
      step(1'b1, 4'b0110, 4'b0000, 4'b1000, 4'b0001);

      // enable low: strobes stop after one edge, pointer holds
      step(1'b0, 4'b0110, 4'b0000, 4'b0000, 4'b0000);
      step(1'b0, 4'b0110, 4'b0000, 4'b0000, 4'b0000);
      step(1'b1, 4'b0110, 4'b0000, 4'b0001, 4'b0010);

      // Asynchronous reset while strobes are high
      @(negedge clk);
      #2;
      reset = 1'b1; enable = 1'b0;
      #1;
      chk("arst_pop",  64'({pop_F3, pop_F2, pop_F1, pop_F0}), 64'd0);
      chk("arst_push", 64'({push_F3, push_F2, push_F1, push_F0}), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_out",  64'({out_FIFO_3, out_FIFO_2, out_FIFO_1, out_FIFO_0}), 64'd0);
      exp_out = '0;
      @(negedge clk);
      reset = 1'b0;

      // After reset, lowest eligible index (P1) wins first
      step(1'b1, 4'b0001, 4'b0000, 4'b0010, 4'b1000);
      step(1'b1, 4'b0001, 4'b0000, 4'b0100, 4'b0100);

      @(negedge clk);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'd0);

`ifdef RR_STATS_EN
      chk("gcnt2_after_rst", 64'(grant_cnt_2), 64'd1);
      chk("gcnt0_after_rst", 64'(grant_cnt_0), 64'd0);
      chk("stall_after_rst", 64'(stall_cnt), 64'd0);
      enable = 1'b1; empty_v = 4'b1101; af_v = 4'b0000;
      repeat (620) @(negedge clk);
      chk("gcnt1_sat", 64'(grant_cnt_1), 64'd255);
      chk("stall_sat", 64'(stall_cnt), 64'd255);
      stats_clr = 1'b1;
      repeat (2) @(negedge clk);
      stats_clr = 1'b0;
      chk("gcnt1_clr", 64'(grant_cnt_1), 64'd0);
      chk("stall_clr", 64'(stall_cnt), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
